cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Microsequencer for the 8-bit accumulator CPU: fetch/execute state machine.
- Decodes the instruction register (IR) and flags, and drives every memory, bus, register-file, pointer-pair and ALU enable.
- Sits between IR/flags registers and the datapath; all datapath registers capture on the falling clock edge, so every strobe here is held stable for a full cycle.

Parameters:
- none

Ports:
- clk  in  1  system clock; state advances on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ir  in  8  instruction register contents.
- flags  in  4  bit0 Z, bit1 C, bit2 S, bit3 O.
- n_oe_mem  out  1  memory output enable, active-low.
- n_we_mem  out  1  memory write enable, active-low.
- n_oe_d_di  out  1  external data bus onto internal bus, active-low.
- we_ir  out  1  IR load.
- inc_ip  out  1  increment instruction pointer.
- addr_dp  out  1  address source: 1 = data pointer (DP), 0 = instruction pointer (IP).
- p_selector  out  1  pointer write target: 0 = IP, 1 = DP.
- n_we_pl / n_we_ph  out  1 each  pointer low/high byte write, active-low.
- we_a / we_b  out  1 each  register A/B write.
- n_oe_pl_alu / n_oe_ph_alu / n_oe_b_alu / n_oe_zero_alu  out  1 each  ALU B-operand source, active-low; exactly one is low during an ALU op, otherwise all high.
- n_oe_a_d / n_oe_b_d  out  1 each  A/B onto external data bus, active-low.
- n_we_flags  out  1  flags load, active-low.
- n_oe_alu_di  out  1  ALU result onto internal bus, active-low.

Behaviour:
- States: FETCH, EXEC, EXEC2. On reset state = FETCH; in the reset cycle all active-low outputs are high and all active-high outputs are low.
- Outputs are a registered-state Moore decode (state + ir), glitch-free within a cycle.
- FETCH: addr_dp=0, n_oe_mem=0, we_ir=1, inc_ip=1. Next state EXEC.
- Decode in EXEC (ir[7:4]):
  - 1xxx ALU: op = ir[6:3] and invert = ir[2], both consumed directly by the ALU. B source from ir[1:0]: 00 B, 01 zero, 10 PL, 11 PH. Drive n_oe_alu_di=0, we_a=1, n_we_flags=0. Next FETCH.
  - 0000 LD: addr_dp=1, n_oe_mem=0, n_oe_d_di=0; ir[0] selects the target (0 -> we_a, 1 -> we_b). Next FETCH.
  - 0001 ST: addr_dp=1, n_we_mem=0, n_oe_mem=1; ir[0] selects the source (0 -> n_oe_a_d=0, 1 -> n_oe_b_d=0). Next FETCH.
  - 0010 LDI: addr_dp=0, n_oe_mem=0, n_oe_d_di=0, inc_ip=1; ir[0] selects the target register. Next FETCH.
  - 0011 LDP: immediate byte into a pointer. addr_dp=0, n_oe_mem=0, n_oe_d_di=0, inc_ip=1, p_selector=1 (DP only). ir[0]: 0 -> n_we_pl=0, 1 -> n_we_ph=0. Next FETCH.
  - 0100 JMP, conditional: flag index = ir[3:2]; cond = flags[idx] XOR ir[1]; ir[0]=1 means unconditional.
    - If taken: go to EXEC2. EXEC2 drives p_selector=0, n_we_pl=0, n_we_ph=0 together, meaning "copy DP into IP" per the pointer_pair contract. inc_ip=0. Next FETCH.
    - Not taken: next FETCH, no strobes.
  - Any other opcode: NOP, next FETCH.
- Mutual exclusion invariants, every cycle:
  - never both n_oe_mem=0 and n_we_mem=0;
  - at most one of n_oe_a_d, n_oe_b_d, n_oe_mem low;
  - at most one internal-bus driver (n_oe_d_di, n_oe_alu_di) low;
  - at most one ALU B source low.
- Reset asserted mid-instruction: the next rising edge returns to FETCH and all strobes go inactive in that same cycle.
- The flags input is sampled only in EXEC of JMP. Flags changed by an ALU op are visible to the following instruction.

Decomposition:
- Shared package cpu_pkg: state enum (FETCH, EXEC, EXEC2); opcode constants (OP_LD, OP_ST, OP_LDI, OP_LDP, OP_JMP); ALU-source codes; flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_S=2, FLAG_O=3).
- One combinational sub-module, cu_decode (state + ir + flags -> strobe vector + next state). The top holds only the state register and reset.

Test Plan:
- Reset: rst=1 for 2 clk then release -> first cycle FETCH with n_oe_mem=0, we_ir=1, inc_ip=1, addr_dp=0; during reset every active-low output is 1.
- ALU op: ir=8'b1_0010_0_10 in EXEC -> n_oe_pl_alu=0 and other B sources 1, n_oe_alu_di=0, we_a=1, n_we_flags=0; next cycle FETCH.
- ST B: ir=8'h11 -> addr_dp=1, n_we_mem=0, n_oe_b_d=0, n_oe_a_d=1, n_oe_mem=1.
- LDI A / LDP high: ir=8'h20 -> n_oe_d_di=0, we_a=1, inc_ip=1. ir=8'h31 -> p_selector=1, n_we_ph=0, n_we_pl=1.
- JMP on Z: ir=8'h40 with flags=4'b0001 -> EXEC2 with p_selector=0, n_we_pl=n_we_ph=0. Same ir with flags=0 -> straight to FETCH, no pointer writes. ir=8'h42 inverts the condition.
- Reset mid-EXEC of ST -> next cycle n_we_mem=1, state FETCH; the bus-exclusion invariants are checked by assertion throughout a random opcode stream.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control path.
package cpu_pkg;

  localparam int unsigned IR_W    = 8;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned OPC_W   = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    EXEC2 = 2'd2
  } state_e;

  localparam logic [OPC_W-1:0] OP_LD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ST  = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h2;
  localparam logic [OPC_W-1:0] OP_LDP = 4'h3;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h4;

  localparam logic [1:0] SRC_B    = 2'b00;
  localparam logic [1:0] SRC_ZERO = 2'b01;
  localparam logic [1:0] SRC_PL   = 2'b10;
  localparam logic [1:0] SRC_PH   = 2'b11;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_O = 3;

  // Every datapath strobe, kept in its pin polarity.
  typedef struct packed {
    logic n_oe_mem;
    logic n_we_mem;
    logic n_oe_d_di;
    logic we_ir;
    logic inc_ip;
    logic addr_dp;
    logic p_selector;
    logic n_we_pl;
    logic n_we_ph;
    logic we_a;
    logic we_b;
    logic n_oe_pl_alu;
    logic n_oe_ph_alu;
    logic n_oe_b_alu;
    logic n_oe_zero_alu;
    logic n_oe_a_d;
    logic n_oe_b_d;
    logic n_we_flags;
    logic n_oe_alu_di;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    n_oe_mem:      1'b1,
    n_we_mem:      1'b1,
    n_oe_d_di:     1'b1,
    we_ir:         1'b0,
    inc_ip:        1'b0,
    addr_dp:       1'b0,
    p_selector:    1'b0,
    n_we_pl:       1'b1,
    n_we_ph:       1'b1,
    we_a:          1'b0,
    we_b:          1'b0,
    n_oe_pl_alu:   1'b1,
    n_oe_ph_alu:   1'b1,
    n_oe_b_alu:    1'b1,
    n_oe_zero_alu: 1'b1,
    n_oe_a_d:      1'b1,
    n_oe_b_d:      1'b1,
    n_we_flags:    1'b1,
    n_oe_alu_di:   1'b1
  };

endpackage

// File: rtl/cu_decode.sv
// Combinational microcode decode: current state, IR and flags to strobes and next state.
module cu_decode
  import cpu_pkg::*;
(
  input  state_e             i_state,
  input  logic [IR_W-1:0]    i_ir,
  input  logic [FLAGS_W-1:0] i_flags,
  output ctrl_t              o_ctrl,
  output state_e             o_next_state
);

  logic w_taken;

  // ir[0] forces the jump; otherwise the selected flag, optionally inverted by ir[1].
  assign w_taken = i_ir[0] | (i_flags[i_ir[3:2]] ^ i_ir[1]);

  always_comb begin
    o_ctrl       = CTRL_IDLE;
    o_next_state = FETCH;
    case (i_state)
      FETCH: begin
        o_ctrl.addr_dp  = 1'b0;
        o_ctrl.n_oe_mem = 1'b0;
        o_ctrl.we_ir    = 1'b1;
        o_ctrl.inc_ip   = 1'b1;
        o_next_state    = EXEC;
      end
      EXEC: begin
        if (i_ir[7]) begin
          o_ctrl.n_oe_alu_di = 1'b0;
          o_ctrl.we_a        = 1'b1;
          o_ctrl.n_we_flags  = 1'b0;
          case (i_ir[1:0])
            SRC_B:    o_ctrl.n_oe_b_alu    = 1'b0;
            SRC_ZERO: o_ctrl.n_oe_zero_alu = 1'b0;
            SRC_PL:   o_ctrl.n_oe_pl_alu   = 1'b0;
            default:  o_ctrl.n_oe_ph_alu   = 1'b0;
          endcase
        end else begin
          case (i_ir[7:4])
            OP_LD: begin
              o_ctrl.addr_dp   = 1'b1;
              o_ctrl.n_oe_mem  = 1'b0;
              o_ctrl.n_oe_d_di = 1'b0;
              o_ctrl.we_a      = ~i_ir[0];
              o_ctrl.we_b      = i_ir[0];
            end
            OP_ST: begin
              o_ctrl.addr_dp  = 1'b1;
              o_ctrl.n_we_mem = 1'b0;
              o_ctrl.n_oe_mem = 1'b1;
              o_ctrl.n_oe_a_d = i_ir[0];
              o_ctrl.n_oe_b_d = ~i_ir[0];
            end
            OP_LDI: begin
              o_ctrl.addr_dp   = 1'b0;
              o_ctrl.n_oe_mem  = 1'b0;
              o_ctrl.n_oe_d_di = 1'b0;
              o_ctrl.inc_ip    = 1'b1;
              o_ctrl.we_a      = ~i_ir[0];
              o_ctrl.we_b      = i_ir[0];
            end
            OP_LDP: begin
              o_ctrl.addr_dp    = 1'b0;
              o_ctrl.n_oe_mem   = 1'b0;
              o_ctrl.n_oe_d_di  = 1'b0;
              o_ctrl.inc_ip     = 1'b1;
              o_ctrl.p_selector = 1'b1;
              o_ctrl.n_we_pl    = i_ir[0];
              o_ctrl.n_we_ph    = ~i_ir[0];
            end
            OP_JMP: begin
              if (w_taken) o_next_state = EXEC2;
            end
            default: ;
          endcase
        end
      end
      EXEC2: begin
        // Both pointer-byte writes with p_selector=0 copy DP into IP.
        o_ctrl.p_selector = 1'b0;
        o_ctrl.n_we_pl    = 1'b0;
        o_ctrl.n_we_ph    = 1'b0;
        o_ctrl.inc_ip     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/execute microsequencer: state register plus decoded strobes.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IR_W-1:0]    ir,
  input  logic [FLAGS_W-1:0] flags,
  output logic               n_oe_mem,
  output logic               n_we_mem,
  output logic               n_oe_d_di,
  output logic               we_ir,
  output logic               inc_ip,
  output logic               addr_dp,
  output logic               p_selector,
  output logic               n_we_pl,
  output logic               n_we_ph,
  output logic               we_a,
  output logic               we_b,
  output logic               n_oe_pl_alu,
  output logic               n_oe_ph_alu,
  output logic               n_oe_b_alu,
  output logic               n_oe_zero_alu,
  output logic               n_oe_a_d,
  output logic               n_oe_b_d,
  output logic               n_we_flags,
  output logic               n_oe_alu_di
);

  state_e r_state;
  logic   r_rst_q;
  state_e w_next_state;
  ctrl_t  w_dec_ctrl;
  ctrl_t  w_ctrl;

  cu_decode u_decode (
    .i_state      (r_state),
    .i_ir         (ir),
    .i_flags      (flags),
    .o_ctrl       (w_dec_ctrl),
    .o_next_state (w_next_state)
  );

  // The cycle after a sampled reset is held idle in FETCH so no strobe fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_rst_q <= 1'b1;
    end else begin
      r_state <= r_rst_q ? FETCH : w_next_state;
      r_rst_q <= 1'b0;
    end
  end

  assign w_ctrl = r_rst_q ? CTRL_IDLE : w_dec_ctrl;

  assign n_oe_mem      = w_ctrl.n_oe_mem;
  assign n_we_mem      = w_ctrl.n_we_mem;
  assign n_oe_d_di     = w_ctrl.n_oe_d_di;
  assign we_ir         = w_ctrl.we_ir;
  assign inc_ip        = w_ctrl.inc_ip;
  assign addr_dp       = w_ctrl.addr_dp;
  assign p_selector    = w_ctrl.p_selector;
  assign n_we_pl       = w_ctrl.n_we_pl;
  assign n_we_ph       = w_ctrl.n_we_ph;
  assign we_a          = w_ctrl.we_a;
  assign we_b          = w_ctrl.we_b;
  assign n_oe_pl_alu   = w_ctrl.n_oe_pl_alu;
  assign n_oe_ph_alu   = w_ctrl.n_oe_ph_alu;
  assign n_oe_b_alu    = w_ctrl.n_oe_b_alu;
  assign n_oe_zero_alu = w_ctrl.n_oe_zero_alu;
  assign n_oe_a_d      = w_ctrl.n_oe_a_d;
  assign n_oe_b_d      = w_ctrl.n_oe_b_d;
  assign n_we_flags    = w_ctrl.n_we_flags;
  assign n_oe_alu_di   = w_ctrl.n_oe_alu_di;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed scoreboard bench for cpu_control_unit plus bus-exclusion checks on a random stream.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic [3:0] flags;
  logic n_oe_mem, n_we_mem, n_oe_d_di, we_ir, inc_ip, addr_dp, p_selector;
  logic n_we_pl, n_we_ph, we_a, we_b;
  logic n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu, n_oe_zero_alu;
  logic n_oe_a_d, n_oe_b_d, n_we_flags, n_oe_alu_di;

  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  ctrl_t exp_q[$];
  string tag_q[$];
  ctrl_t obs;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .flags(flags),
    .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem), .n_oe_d_di(n_oe_d_di),
    .we_ir(we_ir), .inc_ip(inc_ip), .addr_dp(addr_dp), .p_selector(p_selector),
    .n_we_pl(n_we_pl), .n_we_ph(n_we_ph), .we_a(we_a), .we_b(we_b),
    .n_oe_pl_alu(n_oe_pl_alu), .n_oe_ph_alu(n_oe_ph_alu),
    .n_oe_b_alu(n_oe_b_alu), .n_oe_zero_alu(n_oe_zero_alu),
    .n_oe_a_d(n_oe_a_d), .n_oe_b_d(n_oe_b_d),
    .n_we_flags(n_we_flags), .n_oe_alu_di(n_oe_alu_di)
  );

  always_comb begin
    obs               = '0;
    obs.n_oe_mem      = n_oe_mem;
    obs.n_we_mem      = n_we_mem;
    obs.n_oe_d_di     = n_oe_d_di;
    obs.we_ir         = we_ir;
    obs.inc_ip        = inc_ip;
    obs.addr_dp       = addr_dp;
    obs.p_selector    = p_selector;
    obs.n_we_pl       = n_we_pl;
    obs.n_we_ph       = n_we_ph;
    obs.we_a          = we_a;
    obs.we_b          = we_b;
    obs.n_oe_pl_alu   = n_oe_pl_alu;
    obs.n_oe_ph_alu   = n_oe_ph_alu;
    obs.n_oe_b_alu    = n_oe_b_alu;
    obs.n_oe_zero_alu = n_oe_zero_alu;
    obs.n_oe_a_d      = n_oe_a_d;
    obs.n_oe_b_d      = n_oe_b_d;
    obs.n_we_flags    = n_we_flags;
    obs.n_oe_alu_di   = n_oe_alu_di;
  end

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '1;
    c.we_ir = 1'b0; c.inc_ip = 1'b0; c.addr_dp = 1'b0; c.p_selector = 1'b0;
    c.we_a = 1'b0;  c.we_b = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t e_fetch();
    ctrl_t c = idle();
    c.n_oe_mem = 1'b0; c.we_ir = 1'b1; c.inc_ip = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t e_alu(input logic [1:0] src);
    ctrl_t c = idle();
    c.n_oe_alu_di = 1'b0; c.we_a = 1'b1; c.n_we_flags = 1'b0;
    if (src == 2'b00) c.n_oe_b_alu = 1'b0;
    if (src == 2'b01) c.n_oe_zero_alu = 1'b0;
    if (src == 2'b10) c.n_oe_pl_alu = 1'b0;
    if (src == 2'b11) c.n_oe_ph_alu = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t e_ld(input bit to_b);
    ctrl_t c = idle();
    c.addr_dp = 1'b1; c.n_oe_mem = 1'b0; c.n_oe_d_di = 1'b0;
    if (to_b) c.we_b = 1'b1; else c.we_a = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t e_st(input bit from_b);
    ctrl_t c = idle();
    c.addr_dp = 1'b1; c.n_we_mem = 1'b0;
    if (from_b) c.n_oe_b_d = 1'b0; else c.n_oe_a_d = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t e_ldi(input bit to_b);
    ctrl_t c = idle();
    c.n_oe_mem = 1'b0; c.n_oe_d_di = 1'b0; c.inc_ip = 1'b1;
    if (to_b) c.we_b = 1'b1; else c.we_a = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t e_ldp(input bit high);
    ctrl_t c = idle();
    c.n_oe_mem = 1'b0; c.n_oe_d_di = 1'b0; c.inc_ip = 1'b1; c.p_selector = 1'b1;
    if (high) c.n_we_ph = 1'b0; else c.n_we_pl = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t e_jmp2();
    ctrl_t c = idle();
    c.n_we_pl = 1'b0; c.n_we_ph = 1'b0;
    return c;
  endfunction

  // Advance one cycle and compare the oldest scoreboard entry against the outputs.
  task automatic check_cycle();
    ctrl_t e;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%05h expected=%05h", t, obs, e);
      end
    end
  endtask

  // Issue one instruction: push its FETCH/EXEC(/EXEC2) expectations, then retire them.
  task automatic instr(input logic [7:0] op, input logic [3:0] fl,
                       input ctrl_t ex, input bit taken, input string t);
    exp_q.push_back(e_fetch()); tag_q.push_back({t, "_fetch"});
    exp_q.push_back(ex);        tag_q.push_back({t, "_exec"});
    if (taken) begin
      exp_q.push_back(e_jmp2()); tag_q.push_back({t, "_exec2"});
    end
    check_cycle();
    ir    = op;
    flags = fl;
    check_cycle();
    if (taken) check_cycle();
  endtask

  // Bus-exclusion invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      assert (!(n_oe_mem === 1'b0 && n_we_mem === 1'b0)) else begin
        n_err++;
        $error("FAIL inv_mem_rw observed=oe%b_we%b expected=not_both_low", n_oe_mem, n_we_mem);
      end
      n_cmp++;
      assert ($countones(~{n_oe_a_d, n_oe_b_d, n_oe_mem}) <= 1) else begin
        n_err++;
        $error("FAIL inv_dbus observed=%b expected=at_most_one_low", {n_oe_a_d, n_oe_b_d, n_oe_mem});
      end
      n_cmp++;
      assert ($countones(~{n_oe_d_di, n_oe_alu_di}) <= 1) else begin
        n_err++;
        $error("FAIL inv_ibus observed=%b expected=at_most_one_low", {n_oe_d_di, n_oe_alu_di});
      end
      n_cmp++;
      assert ($countones(~{n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu, n_oe_zero_alu}) <= 1) else begin
        n_err++;
        $error("FAIL inv_alu_src observed=%b expected=at_most_one_low",
               {n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu, n_oe_zero_alu});
      end
    end
  end

  initial begin
    rst   = 1'b1;
    ir    = 8'h00;
    flags = 4'h0;
    exp_q.push_back(idle()); tag_q.push_back("reset_1");
    exp_q.push_back(idle()); tag_q.push_back("reset_2");
    check_cycle();
    chk_en = 1'b1;
    check_cycle();
    rst = 1'b0;

    instr(8'b1_0010_0_10, 4'h0, e_alu(2'b10), 1'b0, "alu_pl");
    instr(8'h80,          4'h0, e_alu(2'b00), 1'b0, "alu_b");
    instr(8'hA9,          4'h0, e_alu(2'b01), 1'b0, "alu_zero");
    instr(8'hC7,          4'h0, e_alu(2'b11), 1'b0, "alu_ph");
    instr(8'h00,          4'h0, e_ld(1'b0),   1'b0, "ld_a");
    instr(8'h01,          4'h0, e_ld(1'b1),   1'b0, "ld_b");
    instr(8'h11,          4'h0, e_st(1'b1),   1'b0, "st_b");
    instr(8'h10,          4'h0, e_st(1'b0),   1'b0, "st_a");
    instr(8'h20,          4'h0, e_ldi(1'b0),  1'b0, "ldi_a");
    instr(8'h21,          4'h0, e_ldi(1'b1),  1'b0, "ldi_b");
    instr(8'h31,          4'h0, e_ldp(1'b1),  1'b0, "ldp_h");
    instr(8'h30,          4'h0, e_ldp(1'b0),  1'b0, "ldp_l");
    instr(8'h40,          4'b0001, idle(),    1'b1, "jz_taken");
    instr(8'h40,          4'b0000, idle(),    1'b0, "jz_not");
    instr(8'h42,          4'b0000, idle(),    1'b1, "jnz_taken");
    instr(8'h42,          4'b0001, idle(),    1'b0, "jnz_not");
    instr(8'h41,          4'b0000, idle(),    1'b1, "jmp_always");
    instr(8'h4C,          4'b1000, idle(),    1'b1, "jo_taken");
    instr(8'h44,          4'b1101, idle(),    1'b0, "jc_not");
    instr(8'h50,          4'hF,    idle(),    1'b0, "nop");

    // Reset arriving in the EXEC cycle of a store.
    exp_q.push_back(e_fetch()); tag_q.push_back("strst_fetch");
    exp_q.push_back(e_st(1'b1)); tag_q.push_back("strst_exec");
    exp_q.push_back(idle());    tag_q.push_back("strst_reset");
    check_cycle();
    ir = 8'h11;
    check_cycle();
    rst = 1'b1;
    check_cycle();
    rst = 1'b0;
    instr(8'h20, 4'h0, e_ldi(1'b0), 1'b0, "post_reset");

    // Random opcode stream for the invariant monitor.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      ir    = 8'($urandom);
      flags = 4'($urandom);
      rst   = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
